valu_issue_ctrl: RTL
====================

Name: valu_issue_ctrl

Overview:
- In-order issue and writeback controller for the 8-stage pipelined vector ALU.
- Accepts decoded ops over a valid/ready handshake and drives the ALU `op`, `imm` and `en` inputs.
- Tracks in-flight destinations in a shadow pipeline, blocks RAW hazards, and presents retiring results to the register-file writeback port with backpressure.
- Sits between the decode stage and the vector/scalar register files.

Parameters:
- LATENCY, 8, enabled cycles from ALU input sample to result at the ALU output.
- REGW, 5, register index width (32 scalar + 32 vector registers).
- OPW, 5, ALU opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decoder has an op.
- issue_ready  out  1  op accepted this cycle when issue_valid && issue_ready.
- issue_op  in  OPW  ALU opcode (valu_pkg encoding).
- issue_imm  in  8  swizzle/index immediate.
- issue_dst  in  REGW  destination register index.
- issue_dst_vec  in  1  1 = vector destination, 0 = scalar destination.
- issue_src_vld  in  3  valid bits for src0, src1 and the scalar source.
- issue_src0, issue_src1  in  REGW  vector source registers.
- issue_srcs  in  REGW  scalar source register (r1).
- flush  in  1  kill all in-flight ops.
- alu_en  out  1  ALU pipeline advance enable.
- alu_op  out  OPW  opcode presented to the ALU.
- alu_imm  out  8  immediate of the op currently retiring.
- wb_valid  out  1  retiring op result is valid.
- wb_ready  in  1  register file accepts the result.
- wb_dst  out  REGW  destination of the retiring op.
- wb_dst_vec  out  1  destination class of the retiring op.
- wb_op  out  OPW  opcode of the retiring op (selects rout vs vout).

Behaviour:
- Shadow pipeline: stages 1..LATENCY, each holding {vld, op, imm, dst, dst_vec}. Stage LATENCY is the retiring slot.
- Stall rule: alu_en = !(stage[LATENCY].vld && !wb_ready). When alu_en=0:
  - all shadow stages hold;
  - issue_ready=0.
- Hazard: asserted if any valid shadow stage k in 1..LATENCY has dst_vec/dst matching an enabled source of issue. Matching rules:
  - src0/src1 compare against vector destinations only;
  - srcs compares against scalar destinations only.
- Issue: issue_ready = alu_en && !hazard && !flush.
- On an enabled edge:
  - stage[1] loads {issue_valid && issue_ready, issue_op, issue_imm, dst, dst_vec};
  - stage[k] loads stage[k-1].
  - A non-accepted cycle inserts a bubble (vld=0).
- alu_op = issue_op when issue_valid, otherwise 0 (Fadd). The ALU samples its inputs only on enabled edges.
- alu_imm = stage[LATENCY].imm. The ALU uses imm combinationally at its output, so the retiring op's immediate must be presented there.
- wb_valid = stage[LATENCY].vld, except that op Vsma produces no result and retires with wb_valid=0.
- wb_dst, wb_dst_vec and wb_op are taken from stage[LATENCY]. Retire occurs on wb_valid && wb_ready.
- Latency: an op accepted at edge N, with no stalls, gives wb_valid high in the cycle after edge N+LATENCY-1 (8 enabled edges after sample). Each stall cycle adds exactly one cycle.
- Back-to-back: one op per cycle sustained when there are no hazards and wb_ready stays high.
- Flush: synchronous; clears all stage vld bits on the next edge regardless of alu_en. wb_valid is forced to 0 in the flush cycle. issue_ready=0 during flush.
- Reset (any time, including mid-operation): all vld=0, stage fields 0, wb_valid=0, issue_ready=0 while rst is high, alu_en=1, alu_op=0, alu_imm=0.
- Same-cycle retire and dependent issue: the retiring stage still counts for the hazard check. The dependent op issues the cycle after the retire.
- Ops with unknown opcode (> Vmin): accepted and retired with wb_valid=0.

Optional Feature:
- VALU_PERF_CNT_EN: adds outputs perf_issued (32), perf_stall_wb (32) and perf_stall_haz (32). These are saturating counters of:
  - accepted ops;
  - cycles with alu_en=0;
  - cycles with issue_valid && alu_en && hazard.
- Counters clear on rst only.
- Without the macro, the ports and counters are absent.

Decomposition:
- valu_pkg holds:
  - the opcode enum in ALU order: Fadd=0, Fsub, Fmult, Vadd, Vsub, Vmult, Vdot, Vdota, Vindx, Vreduce, Vsplat, Vswizzle, Vsadd, Vssub, Vsmult, Vsma, Vcompsel, Vmax, Vmin=18;
  - LATENCY;
  - the shadow-stage struct typedef;
  - the function op_writes(op).
- One sub-module: valu_hazard_chk, purely combinational. Inputs are the shadow stage array and the source tags; output is hazard.

Test Plan:
- Reset mid-stream: 3 ops in flight, rst pulse → wb_valid=0, no retire ever appears for those ops, issue_ready=1 after release.
- Single Vadd dst=v4, wb_ready=1 → wb_valid exactly 8 cycles after accept, wb_dst=4, wb_dst_vec=1, wb_op=3.
- 8 independent ops back-to-back, wb_ready=1 → 8 consecutive wb_valid cycles with dst order preserved, issue_ready never low.
- Vadd dst=v2, then Vmult src0=v2 → issue_ready low for 8 cycles; second op accepted the cycle after the first retires.
- wb_ready held low for 3 cycles while stage 8 is valid → alu_en=0 for 3 cycles, no shadow advance; then a Vswizzle retires with alu_imm=8'hE4 as issued.
- flush with 5 ops in flight → no wb_valid afterwards; a Vsma issued alone → no wb_valid at latency.

Source files
------------

// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - shared types and constants for the vector ALU issue controller
package valu_pkg;

  localparam int LATENCY = 8;
  localparam int REGW    = 5;
  localparam int OPW     = 5;

  // Opcode encoding in ALU order
  typedef enum logic [OPW-1:0] {
    Fadd     = 5'd0,
    Fsub     = 5'd1,
    Fmult    = 5'd2,
    Vadd     = 5'd3,
    Vsub     = 5'd4,
    Vmult    = 5'd5,
    Vdot     = 5'd6,
    Vdota    = 5'd7,
    Vindx    = 5'd8,
    Vreduce  = 5'd9,
    Vsplat   = 5'd10,
    Vswizzle = 5'd11,
    Vsadd    = 5'd12,
    Vssub    = 5'd13,
    Vsmult   = 5'd14,
    Vsma     = 5'd15,
    Vcompsel = 5'd16,
    Vmax     = 5'd17,
    Vmin     = 5'd18
  } valu_op_e;

  // One slot of the shadow pipeline that mirrors the ALU stages
  typedef struct packed {
    logic            vld;
    logic [OPW-1:0]  op;
    logic [7:0]      imm;
    logic [REGW-1:0] dst;
    logic            dst_vec;
  } shadow_stage_t;

  // Vsma and unknown opcodes retire without producing a register result
  function automatic logic op_writes(input logic [OPW-1:0] op);
    return (int'(op) <= int'(Vmin)) && (int'(op) != int'(Vsma));
  endfunction

endpackage

// File: rtl/valu_hazard_chk.sv
// rtl/valu_hazard_chk.sv - RAW hazard detection against in-flight destinations
module valu_hazard_chk
  import valu_pkg::*;
(
  input  shadow_stage_t [LATENCY-1:0] stages_i,
  input  logic [2:0]                  src_vld_i,
  input  logic [REGW-1:0]             src0_i,
  input  logic [REGW-1:0]             src1_i,
  input  logic [REGW-1:0]             srcs_i,
  output logic                        hazard_o
);

  // Vector sources only collide with vector destinations, scalar with scalar
  always_comb begin
    hazard_o = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      if (stages_i[k].vld) begin
        if (src_vld_i[0] && stages_i[k].dst_vec && (stages_i[k].dst == src0_i)) hazard_o = 1'b1;
        if (src_vld_i[1] && stages_i[k].dst_vec && (stages_i[k].dst == src1_i)) hazard_o = 1'b1;
        if (src_vld_i[2] && !stages_i[k].dst_vec && (stages_i[k].dst == srcs_i)) hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/valu_issue_ctrl.sv
// rtl/valu_issue_ctrl.sv - in-order issue/writeback control for the pipelined vector ALU (optional VALU_PERF_CNT_EN)
module valu_issue_ctrl
  import valu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [OPW-1:0]  issue_op,
  input  logic [7:0]      issue_imm,
  input  logic [REGW-1:0] issue_dst,
  input  logic            issue_dst_vec,
  input  logic [2:0]      issue_src_vld,
  input  logic [REGW-1:0] issue_src0,
  input  logic [REGW-1:0] issue_src1,
  input  logic [REGW-1:0] issue_srcs,
  input  logic            flush,
  output logic            alu_en,
  output logic [OPW-1:0]  alu_op,
  output logic [7:0]      alu_imm,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [REGW-1:0] wb_dst,
  output logic            wb_dst_vec,
  output logic [OPW-1:0]  wb_op
`ifdef VALU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall_wb,
  output logic [31:0]     perf_stall_haz
`endif
);

  shadow_stage_t [LATENCY-1:0] stage_q, stage_d;
  shadow_stage_t               retire;
  logic                        hazard;
  logic                        accept;

  valu_hazard_chk u_hazard_chk (
    .stages_i  (stage_q),
    .src_vld_i (issue_src_vld),
    .src0_i    (issue_src0),
    .src1_i    (issue_src1),
    .srcs_i    (issue_srcs),
    .hazard_o  (hazard)
  );

  // Retire slot drives writeback; a blocked retire freezes the whole ALU
  always_comb begin
    retire      = stage_q[LATENCY-1];
    alu_en      = !(retire.vld && !wb_ready);
    issue_ready = !rst && alu_en && !hazard && !flush;
    accept      = issue_valid && issue_ready;
    alu_op      = issue_valid ? issue_op : OPW'(Fadd);
    alu_imm     = retire.imm;
    wb_valid    = retire.vld && op_writes(retire.op) && !flush;
    wb_dst      = retire.dst;
    wb_dst_vec  = retire.dst_vec;
    wb_op       = retire.op;
  end

  // Shadow pipeline next state: flush kills everything, else shift on enable
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      for (int k = 0; k < LATENCY; k++) stage_d[k].vld = 1'b0;
    end else if (alu_en) begin
      stage_d[0] = '{vld: accept, op: issue_op, imm: issue_imm,
                     dst: issue_dst, dst_vec: issue_dst_vec};
      for (int k = 1; k < LATENCY; k++) stage_d[k] = stage_q[k-1];
    end
  end

  // Shadow pipeline state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

`ifdef VALU_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_stall_wb_q, perf_stall_haz_q;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q    <= '0;
      perf_stall_wb_q  <= '0;
      perf_stall_haz_q <= '0;
    end else begin
      if (accept && (perf_issued_q != '1)) perf_issued_q <= perf_issued_q + 32'd1;
      if (!alu_en && (perf_stall_wb_q != '1)) perf_stall_wb_q <= perf_stall_wb_q + 32'd1;
      if (issue_valid && alu_en && hazard && (perf_stall_haz_q != '1))
        perf_stall_haz_q <= perf_stall_haz_q + 32'd1;
    end
  end

  assign perf_issued    = perf_issued_q;
  assign perf_stall_wb  = perf_stall_wb_q;
  assign perf_stall_haz = perf_stall_haz_q;
`endif

endmodule
